// File: rtl/microsequencer_next_state.sv
`default_nettype none
// ============================================================================
// Module   : microsequencer_next_state
// Purpose  : Control-state register and next-state selection for the ARM
//            control unit, with condition evaluation and wait watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module microsequencer_next_state #(
    parameter int unsigned          STATE_W     = 7,
    parameter logic [STATE_W-1:0]   RESET_STATE = '0,
    parameter logic [7:0]           MAX_WAIT    = 8'd255,
    parameter logic [STATE_W-1:0]   TRAP_STATE  = {STATE_W{1'b1}}
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [STATE_W-1:0] EncState,
    input  logic [STATE_W-1:0] CRJump,
    input  logic [2:0]         N,
    input  logic [1:0]         CondSel,
    input  logic               Inv,
    input  logic               MOC,
    input  logic [3:0]         IRCond,
    input  logic [3:0]         Flags,
    output logic [STATE_W-1:0] State,
    output logic               CondTrue,
    output logic               Timeout,
    output logic [7:0]         WaitCount
);

    localparam logic [2:0] c_N_DECODE = 3'b000;
    localparam logic [2:0] c_N_INC    = 3'b001;
    localparam logic [2:0] c_N_JUMP   = 3'b010;
    localparam logic [2:0] c_N_CJUMP  = 3'b011;
    localparam logic [2:0] c_N_WAIT   = 3'b100;

    localparam logic [1:0] c_SEL_MOC  = 2'b00;
    localparam logic [1:0] c_SEL_ARM  = 2'b01;
    localparam logic [1:0] c_SEL_ONE  = 2'b10;

    localparam logic [7:0] c_WAIT_LAST = MAX_WAIT - 8'd1;

    logic [STATE_W-1:0] r_state;
    logic [7:0]         r_wait_count;
    logic               r_timeout;

    logic               w_flag_n, w_flag_z, w_flag_c, w_flag_v;
    logic               w_arm_ok;
    logic               w_src;
    logic               w_cnd;
    logic [STATE_W-1:0] w_inc;
    logic [STATE_W-1:0] w_next;
    logic               w_hold;
    logic               w_trap;

    assign {w_flag_n, w_flag_z, w_flag_c, w_flag_v} = Flags;

    always_comb begin
        w_arm_ok = 1'b0;
        case (IRCond)
            4'b0000: w_arm_ok = w_flag_z;
            4'b0001: w_arm_ok = !w_flag_z;
            4'b0010: w_arm_ok = w_flag_c;
            4'b0011: w_arm_ok = !w_flag_c;
            4'b0100: w_arm_ok = w_flag_n;
            4'b0101: w_arm_ok = !w_flag_n;
            4'b0110: w_arm_ok = w_flag_v;
            4'b0111: w_arm_ok = !w_flag_v;
            4'b1000: w_arm_ok = w_flag_c & !w_flag_z;
            4'b1001: w_arm_ok = !w_flag_c | w_flag_z;
            4'b1010: w_arm_ok = (w_flag_n == w_flag_v);
            4'b1011: w_arm_ok = (w_flag_n != w_flag_v);
            4'b1100: w_arm_ok = !w_flag_z & (w_flag_n == w_flag_v);
            4'b1101: w_arm_ok = w_flag_z | (w_flag_n != w_flag_v);
            4'b1110: w_arm_ok = 1'b1;
            default: w_arm_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_src = 1'b0;
        case (CondSel)
            c_SEL_MOC: w_src = MOC;
            c_SEL_ARM: w_src = w_arm_ok;
            c_SEL_ONE: w_src = 1'b1;
            default:   w_src = 1'b0;
        endcase
    end

    assign w_cnd    = w_src ^ Inv;
    assign CondTrue = w_cnd;
    assign w_inc    = r_state + STATE_W'(1);

    // Mux selects whole sources, so an unselected input never reaches State.
    always_comb begin
        w_next = RESET_STATE;
        case (N)
            c_N_DECODE: w_next = EncState;
            c_N_INC:    w_next = w_inc;
            c_N_JUMP:   w_next = CRJump;
            c_N_CJUMP:  w_next = w_cnd ? CRJump : w_inc;
            c_N_WAIT:   w_next = w_cnd ? r_state : w_inc;
            default:    w_next = RESET_STATE;
        endcase
    end

    assign w_hold = (N == c_N_WAIT) && w_cnd;
    assign w_trap = w_hold && (r_wait_count == c_WAIT_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= RESET_STATE;
            r_wait_count <= 8'd0;
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= w_trap;
            if (w_trap) begin
                r_state      <= TRAP_STATE;
                r_wait_count <= 8'd0;
            end else begin
                r_state      <= w_next;
                r_wait_count <= w_hold ? (r_wait_count + 8'd1) : 8'd0;
            end
        end
    end

    assign State     = r_state;
    assign WaitCount = r_wait_count;
    assign Timeout   = r_timeout;

endmodule
`default_nettype wire
